pistorm_host_seq: RTL
=====================

// Module: pistorm_host_seq
// PURPOSE
// Host-side master for the PiStorm GPIO register protocol (PI_A/PI_RD/PI_WR/PI_D,
// PI_TXN_IN_PROGRESS, PI_IPL_ZERO). Replaces Pi software bit-banging when an FPGA host
// drives the CPLD bus bridge: it turns one 68K access request into the DATA/ADDR_LO/ADDR_HI
// write sequence, waits for the 68K cycle to end, reads back data, and tracks IPL/reset.
// PARAMETERS
// SETUP_CYC   2      clk cycles PI_A/PI_D stable before strobe rises (>=1)
// STROBE_CYC  3      clk cycles PI_WR/PI_RD held high (>=1); read sampled on last strobe cycle
// HOLD_CYC    2      clk cycles PI_A/PI_D held after strobe falls (>=1)
// SYNC_STAGES 2      synchroniser depth for pi_txn_in_progress and pi_ipl_zero (>=2)
// TIMEOUT     4095   clk cycles allowed for txn to clear before rsp_err; width 12 bits
// PORTS
// clk          in   1   system clock
// op_reqrst    in   1   reset, asynchronous, active-high
// req_valid    in   1   access request; accepted on clk edge when req_valid & req_ready
// req_ready    out  1   high only in IDLE with no higher-priority work pending
// req_addr     in   24  68K byte address; bit0 selects LDS for byte access
// req_wdata    in   16  write data (ignored for reads)
// req_byte     in   1   1=byte access, 0=word
// req_read     in   1   1=read, 0=write
// rsp_valid    out  1   one-cycle pulse: access finished
// rsp_rdata    out  16  read data, valid with rsp_valid (0 for writes)
// rsp_err      out  1   with rsp_valid: TIMEOUT expired
// bus_rst_req  in   1   level: 1=hold 68K bus in reset, 0=run; change triggers STATUS write
// ipl_o        out  3   last IPL level read from STATUS (active-high encoding)
// pi_a         out  2   register select: 0 DATA, 1 ADDR_LO, 2 ADDR_HI, 3 STATUS
// pi_rd/pi_wr  out  1   read/write strobes, never high together
// pi_d_o/oe/i  out/out/in 16/1/16  GPIO data out, output enable, data in
// pi_txn_in_progress in 1; pi_ipl_zero in 1 (asynchronous to clk)
// BEHAVIOUR
// - Reset: state IDLE; pi_a=0, pi_rd=0, pi_wr=0, pi_d_oe=0, pi_d_o=0, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0, ipl_o=0, req_ready=1, rst_shadow=1 (bridge powers up in reset).
//   Reset mid-access drops strobes immediately; no response is issued for the lost access.
// - Register formats: ADDR_LO d[15:1]=A[15:1], d[0]=A0; ADDR_HI d[7:0]=A[23:16], d[8]=byte,
//   d[9]=read, d[15:10]=0; STATUS write d[1]=!bus_rst_req, others 0; STATUS read ipl=d[15:13].
// - Every register op is a PHASE: SETUP_CYC (pi_a, pi_d_o/oe valid) -> STROBE_CYC strobe
//   -> HOLD_CYC; pi_a and pi_d_o never change while any strobe is high or in SETUP/HOLD.
//   pi_d_oe=1 only for write phases; 0 for read phases and IDLE.
// - IDLE priority (one pick per cycle): (1) bus_rst_req != rst_shadow -> ST_RST write,
//   rst_shadow<=bus_rst_req; (2) ipl_zero_sync==0 and ipl_poll_due -> ST_IPL STATUS read;
//   (3) req_valid -> latch request, req_ready falls the next cycle.
//   ipl_poll_due sets when ipl_zero_sync changes or after each completed access; when
//   ipl_zero_sync==1, ipl_o<=0 directly without a read.
// - Access FSM: WR_DATA (writes only) -> WR_ALO -> WR_AHI -> GUARD -> WAIT_TXN ->
//   RD_DATA (reads only) -> RESP -> IDLE. WR_AHI is the launching write; bridge raises
//   txn during its strobe.
// - GUARD: SYNC_STAGES+1 cycles ignoring txn_sync (stale-low filter). WAIT_TXN: leave
//   on txn_sync==0; counter reaching TIMEOUT -> RESP with rsp_err=1, rsp_rdata=0, no read.
// - RD_DATA: pi_rd phase on DATA; rsp_rdata captured from pi_d_i on last strobe cycle.
// - RESP: rsp_valid=1 exactly one cycle; rsp_rdata/rsp_err held until next RESP.
// - Latency (no contention, defaults): write = 3 phases(21) + GUARD(3) + txn time + RESP;
//   req_valid while not ready is ignored (no queue). Reset (ST_RST) never cancels a running access.
// TESTING
// - Word write A=0xDFF180 D=0x0F00: pi_d sequence 0x0F00@a0, 0xF180@a1, 0x00DF@a2 (d9=0,d8=0);
//   txn model low 40 cyc later -> one rsp_valid, rsp_err=0.
// - Byte read A=0xBFE001, model returns 0x00FC: a1 d=0xE001, a2 d=0x03BF, a0 read ->
//   rsp_rdata=0x00FC; pi_d_oe=0 throughout the read phase.
// - Stuck txn: model holds txn=1 -> rsp_valid with rsp_err=1 after exactly TIMEOUT WAIT cycles.
// - bus_rst_req 1->0 while idle: a3 write d=0x0002 before the next access; req_ready low during it.
// - pi_ipl_zero falls, STATUS returns 0xA000 -> ipl_o=5; pi_ipl_zero rises -> ipl_o=0, no read.
// - op_reqrst asserted during WR_AHI strobe -> pi_wr=0 same cycle; no rsp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/pistorm_host_seq.sv
// pistorm_host_seq: FPGA-side master for the PiStorm GPIO register protocol.
// Sequences 68K accesses as DATA/ADDR_LO/ADDR_HI register phases, polls IPL and drives bus reset.
module pistorm_host_seq #(
    parameter int SETUP_CYC   = 2,
    parameter int STROBE_CYC  = 3,
    parameter int HOLD_CYC    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 4095
) (
    input  logic        clk,
    input  logic        op_reqrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_byte,
    input  logic        req_read,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        bus_rst_req,
    output logic [2:0]  ipl_o,
    output logic [1:0]  pi_a,
    output logic        pi_rd,
    output logic        pi_wr,
    output logic [15:0] pi_d_o,
    output logic        pi_d_oe,
    input  logic [15:0] pi_d_i,
    input  logic        pi_txn_in_progress,
    input  logic        pi_ipl_zero
);
    typedef enum logic [3:0] {
        IDLE, ST_RST, ST_IPL, WR_DATA, WR_ALO, WR_AHI, GUARD, WAIT_TXN, RD_DATA, RESP
    } state_t;

    localparam logic [11:0] PH_LAST = 12'(SETUP_CYC + STROBE_CYC + HOLD_CYC - 1);
    localparam logic [11:0] STB_LO  = 12'(SETUP_CYC);
    localparam logic [11:0] STB_HI  = 12'(SETUP_CYC + STROBE_CYC - 1);
    localparam logic [11:0] GD_LAST = 12'(SYNC_STAGES);
    localparam logic [11:0] TO_LAST = 12'(TIMEOUT - 1);

    state_t state, state_n;
    logic [11:0] cnt;
    logic [23:0] addr_q;
    logic [15:0] wdata_q, rd_buf;
    logic byte_q, read_q, rst_shadow, ipl_prev, ipl_poll_due;
    logic [SYNC_STAGES-1:0] txn_ff, ipl_ff;
    logic txn_sync, ipl_sync, rst_pend, ipl_pend;
    logic phase, rd_ph, ph_done, strobe, cap;

    assign txn_sync = txn_ff[SYNC_STAGES-1];
    assign ipl_sync = ipl_ff[SYNC_STAGES-1];
    assign rst_pend = bus_rst_req != rst_shadow;
    assign ipl_pend = !ipl_sync && ipl_poll_due;
    assign req_ready = state == IDLE && !rst_pend && !ipl_pend;
    assign rsp_valid = state == RESP;

    // cnt restarts on every state change, so one counter times phases, guard and timeout
    assign phase   = state inside {ST_RST, ST_IPL, WR_DATA, WR_ALO, WR_AHI, RD_DATA};
    assign rd_ph   = state == ST_IPL || state == RD_DATA;
    assign ph_done = phase && cnt == PH_LAST;
    assign strobe  = phase && cnt >= STB_LO && cnt <= STB_HI;
    assign cap     = rd_ph && cnt == STB_HI;

    assign pi_wr   = strobe && !rd_ph;
    assign pi_rd   = strobe && rd_ph;
    assign pi_d_oe = phase && !rd_ph;
    assign pi_a    = state == WR_ALO ? 2'd1 :
                     state == WR_AHI ? 2'd2 :
                     (state == ST_RST || state == ST_IPL) ? 2'd3 : 2'd0;
    assign pi_d_o  = state == WR_DATA ? wdata_q :
                     state == WR_ALO  ? addr_q[15:0] :
                     state == WR_AHI  ? {6'b0, read_q, byte_q, addr_q[23:16]} :
                     state == ST_RST  ? {14'b0, !rst_shadow, 1'b0} : 16'h0000;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = rst_pend ? ST_RST : ipl_pend ? ST_IPL :
                                req_valid ? (req_read ? WR_ALO : WR_DATA) : IDLE;
            ST_RST,
            ST_IPL:   state_n = ph_done ? IDLE : state;
            WR_DATA:  state_n = ph_done ? WR_ALO : state;
            WR_ALO:   state_n = ph_done ? WR_AHI : state;
            WR_AHI:   state_n = ph_done ? GUARD : state;
            GUARD:    state_n = cnt == GD_LAST ? WAIT_TXN : state;
            WAIT_TXN: state_n = !txn_sync ? (read_q ? RD_DATA : RESP) :
                                cnt == TO_LAST ? RESP : state;
            RD_DATA:  state_n = ph_done ? RESP : state;
            RESP:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge op_reqrst) begin
        if (op_reqrst) begin
            state        <= IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            byte_q       <= 1'b0;
            read_q       <= 1'b0;
            rst_shadow   <= 1'b1;
            txn_ff       <= '0;
            ipl_ff       <= '1;
            ipl_prev     <= 1'b1;
            ipl_poll_due <= 1'b0;
            rd_buf       <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            ipl_o        <= '0;
        end else begin
            state    <= state_n;
            cnt      <= state_n != state ? 12'd0 : cnt + 12'd1;
            txn_ff   <= {txn_ff[SYNC_STAGES-2:0], pi_txn_in_progress};
            ipl_ff   <= {ipl_ff[SYNC_STAGES-2:0], pi_ipl_zero};
            ipl_prev <= ipl_sync;
            if (state == IDLE && rst_pend)
                rst_shadow <= bus_rst_req;
            if (req_valid && req_ready) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                byte_q  <= req_byte;
                read_q  <= req_read;
            end
            // picking the poll wins over a same-cycle change so one edge yields one read
            ipl_poll_due <= !(state == IDLE && state_n == ST_IPL) &&
                            (ipl_poll_due || ipl_sync != ipl_prev || state == RESP);
            ipl_o <= ipl_sync ? 3'd0 : (state == ST_IPL && cap) ? pi_d_i[15:13] : ipl_o;
            if (state == RD_DATA && cap)
                rd_buf <= pi_d_i;
            if (state == WAIT_TXN && state_n == RESP) begin
                rsp_err   <= txn_sync;
                rsp_rdata <= '0;
            end
            if (state == RD_DATA && state_n == RESP) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= rd_buf;
            end
        end
    end
endmodule
